// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier datapath and its accumulator back end.
package mult_pkg;

   // Multiplier operand and product widths; the accumulator input must match MULT_PROD_W.
   localparam int MULT_IN_W   = 16;
   localparam int MULT_PROD_W = 32;

   // Accumulator FSM: ACCUM collects beats, DONE holds a finished frame result.
   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } acc_state_t;

endpackage : mult_pkg

// File: rtl/egyptian_product_accumulator_if.sv
// Product-in / frame-result-out bus for the product accumulator.
//
// Handshake rules (both directions): a transfer happens on a rising clk edge
// where valid && ready are both 1. The producer holds valid and its payload
// stable until that transfer; ready may be asserted independently of valid,
// and ready never depends combinationally on the opposite side's ready.
interface egyptian_product_accumulator_if #(
   parameter int PROD_W = 32,
   parameter int ACC_W  = 40,
   parameter int CNT_W  = 8
);

   logic              clr;
   logic              in_valid;
   logic              in_ready;
   logic [PROD_W-1:0] in_data;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_data;
   logic [CNT_W-1:0]  out_count;
   logic              out_ovf;

   // Producer of products and consumer of frame results.
   modport master (
      output clr, in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_count, out_ovf
   );

   // The accumulator itself.
   modport slave (
      input  clr, in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_count, out_ovf
   );

endinterface : egyptian_product_accumulator_if

// File: rtl/egyptian_product_accumulator.sv
// Frame accumulator for unsigned multiplier products: sums beats until in_last,
// then presents sum, saturating beat count and sticky overflow for one handshake.
module egyptian_product_accumulator
   import mult_pkg::*;
#(
   parameter int PROD_W = MULT_PROD_W,
   parameter int ACC_W  = 40,
   parameter int CNT_W  = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   egyptian_product_accumulator_if.slave   bus,
   output acc_state_t                      dbg_state
);

   localparam int EXT_W = ACC_W + 1 - PROD_W;

   acc_state_t        state_q, state_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic [ACC_W-1:0]  out_data_q, out_data_d;
   logic [CNT_W-1:0]  out_count_q, out_count_d;
   logic              out_ovf_q, out_ovf_d;

   logic [ACC_W:0]    sum;
   logic [CNT_W-1:0]  cnt_inc;
   logic              in_ready;
   logic              accept;

   // In ACCUM the block is always ready, so in_ready depends only on state.
   assign in_ready = (state_q == ACCUM);
   assign accept   = bus.in_valid && in_ready;

   // One extra bit on the adder captures the carry-out that feeds the sticky overflow.
   assign sum     = {1'b0, acc_q} + {{EXT_W{1'b0}}, bus.in_data};
   assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ACCUM;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: a last beat closes the frame unless clr aborts it; a result handshake reopens.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ACCUM: if (!bus.clr && accept && bus.in_last) state_d = DONE;
         DONE:  if (bus.out_ready)                     state_d = ACCUM;
         default: state_d = ACCUM;
      endcase
   end

   // Outputs decoded from state; results come straight from the held registers.
   always_comb begin
      bus.in_ready  = in_ready;
      bus.out_valid = (state_q == DONE);
      bus.out_data  = out_data_q;
      bus.out_count = out_count_q;
      bus.out_ovf   = out_ovf_q;
      dbg_state     = state_q;
   end

   // Datapath next values: clr beats accept in ACCUM, clr is ignored in DONE.
   always_comb begin
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      out_data_d  = out_data_q;
      out_count_d = out_count_q;
      out_ovf_d   = out_ovf_q;
      case (state_q)
         ACCUM: begin
            if (bus.clr) begin
               acc_d = '0;
               cnt_d = '0;
               ovf_d = 1'b0;
            end else if (accept) begin
               acc_d = sum[ACC_W-1:0];
               cnt_d = cnt_inc;
               ovf_d = ovf_q | sum[ACC_W];
               if (bus.in_last) begin
                  // Result includes the closing beat itself.
                  out_data_d  = sum[ACC_W-1:0];
                  out_count_d = cnt_inc;
                  out_ovf_d   = ovf_q | sum[ACC_W];
               end
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               acc_d = '0;
               cnt_d = '0;
               ovf_d = 1'b0;
            end
         end
         default: begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
         end
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         out_data_q  <= '0;
         out_count_q <= '0;
         out_ovf_q   <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         out_data_q  <= out_data_d;
         out_count_q <= out_count_d;
         out_ovf_q   <= out_ovf_d;
      end
   end

endmodule : egyptian_product_accumulator
